dvi_scanout_reader: RTL and testbench
=====================================

Name: dvi_scanout_reader

Overview:
- Consumer end of the frame buffer's DVI pixel FIFO.
- Pops one 3-bit colour per active pixel and generates 640x480@60 raster timing (hsync/vsync/de).
- Expands each colour to 24-bit RGB for the DVI transmitter.
- Runs on the 100 MHz system clock; an internal divider produces the 25 MHz pixel tick.

Parameters:
PIX_DIV, 4, system clocks per pixel (pixel tick every PIX_DIV clocks)
H_ACTIVE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_ACTIVE, 0, asserted level of hsync/vsync

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
fifo_empty  in  1  DVI FIFO empty; fifo_data valid when low (show-ahead FIFO)
fifo_data  in  3  pixel colour {r,g,b}
fifo_rd_en  out  1  one-clock pop strobe
vga_r  out  8  red
vga_g  out  8  green
vga_b  out  8  blue
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  data enable (active video)
frame_start  out  1  one-clock pulse at pixel (0,0)
underflow_cnt  out  16  saturating count of starved active pixels

Behaviour:
Reset:
- Synchronous, active-high; one clock with rst high is sufficient.
- Reset values: vga_r/g/b=0, de=0, hsync=vsync=~SYNC_ACTIVE, fifo_rd_en=0, frame_start=0, underflow_cnt=0.
- Divider, h_cnt and v_cnt clear to 0; state=WAIT.
- Reset mid-frame aborts the frame immediately; FIFO contents are not flushed.

Pixel tick:
- div counts 0..PIX_DIV-1 in RUN only.
- pix_tick=1 when div==PIX_DIV-1.
- All raster outputs update only on pix_tick clocks and hold otherwise.

State machine:
- WAIT: counters held at 0, outputs at reset values. Go to RUN on the first clock fifo_empty==0.
- RUN: raster free-runs until rst. It never returns to WAIT.

Counters (on pix_tick):
- h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800), wraps to 0.
- On h_cnt wrap, v_cnt increments 0..V_TOTAL-1 (525), wraps to 0.

Registered output decode (on pix_tick), based on current h_cnt/v_cnt:
- active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- de <= active.
- hsync <= SYNC_ACTIVE when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_ACTIVE.
- vsync: same rule on v_cnt using the V params.
- frame_start <= (h_cnt==0 && v_cnt==0) for exactly one clock; cleared on the next clock.
- Output latency: one clock from the counter value to the registered outputs.

FIFO pop:
- fifo_rd_en = pix_tick && active && !fifo_empty (combinational, one clock wide).
- fifo_data is captured on that same edge.
- Never pops outside active video, during WAIT, or when empty.

Colour expansion:
- vga_r = {8{fifo_data[2]}}, vga_g = {8{fifo_data[1]}}, vga_b = {8{fifo_data[0]}}.
- Blanking (de=0): RGB = 0.

Underflow:
- On pix_tick && active && fifo_empty: RGB=0 and de still 1, so raster timing is preserved.
- underflow_cnt increments, saturating at 16'hFFFF.
- No pop occurs; the next available pixel is shown at the next active position (no resync).

Simultaneous events:
- rst overrides everything.
- fifo_empty falling in the same cycle as a pix_tick in WAIT only moves the block to RUN; first raster pixel output comes on the first pix_tick in RUN.

Test Plan:
1. Hold rst 2 clks with fifo_empty=1 for 100 clks -> hsync=vsync=1, de=0, RGB=0, fifo_rd_en never asserted, underflow_cnt=0.
2. Release fifo_empty with FIFO preloaded with 640 words of 3'b101 -> first pop at 4th clock after RUN entry; de=1 with vga_r=FF, vga_g=00, vga_b=FF; exactly 640 pops on line 0, each 4 clks apart.
3. Measure line 0 -> de high 2560 clks, then hsync low for 384 clks starting 64 clks after de falls; hsync period 3200 clks.
4. Run a full frame with FIFO always non-empty -> frame_start pulses 1,680,000 clks apart; vsync low for 6400 clks starting at line 490; 307,200 pops per frame.
5. Force fifo_empty=1 for 10 active pixels mid-line -> RGB=0 for those 10 pixels with de still 1, underflow_cnt=10, no fifo_rd_en; the next pixel shows the next FIFO word.
6. Assert rst for 1 clk mid-frame (line 200) -> next clock outputs equal reset values, state=WAIT; with fifo_empty=0, the raster restarts at (0,0) with a frame_start pulse.

Source files
------------

// File: rtl/dvi_scanout_reader.sv
// ---------------------------------------------------------------------------
// dvi_scanout_reader
//
// Consumer side of the frame buffer's DVI pixel FIFO. Generates a free-running
// raster (640x480@60 by default) from the system clock, using an internal
// divider to make one pixel tick every PIX_DIV clocks. Each active pixel pops
// one 3-bit {r,g,b} colour from a show-ahead FIFO and expands it to 24-bit RGB.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-high reset
//   fifo_empty     FIFO empty flag; fifo_data is valid while this is low
//   fifo_data      3-bit pixel colour {r,g,b} at the FIFO head
//   fifo_rd_en     one-clock pop strobe (combinational)
//   vga_r/g/b      8-bit colour channels, zero while blanking or starved
//   hsync, vsync   sync pulses, asserted at SYNC_ACTIVE
//   de             data enable, high during active video
//   frame_start    one-clock pulse when pixel (0,0) is presented
//   underflow_cnt  saturating count of active pixels that found the FIFO empty
// ---------------------------------------------------------------------------
module dvi_scanout_reader #(
    parameter int   PIX_DIV     = 4,
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fifo_empty,
    input  logic [2:0]  fifo_data,
    output logic        fifo_rd_en,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start,
    output logic [15:0] underflow_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // One extra count of headroom so the sync-window end always fits.
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST   = DW'(PIX_DIV - 1);

    localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SYNC_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SYNC_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);

    localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_SYNC_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SYNC_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [DW-1:0]   div;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            pix_tick;
    logic            active;
    logic            in_hsync;
    logic            in_vsync;
    logic            at_origin;
    logic            pop;

    // State register. Once the raster starts it only stops on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_WAIT;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave WAIT as soon as the FIFO first holds data, so the
    // raster only begins once there is something to show.
    always_comb begin
        state_next = state;
        case (state)
            ST_WAIT: begin
                if (!fifo_empty) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                state_next = ST_RUN;
            end
            default: begin
                state_next = ST_WAIT;
            end
        endcase
    end

    // Pixel-clock divider. Held at zero outside RUN so the first tick after
    // leaving WAIT always lands PIX_DIV clocks after the transition.
    always_ff @(posedge clk) begin
        if (rst || state != ST_RUN) begin
            div <= '0;
        end else if (pix_tick) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    assign pix_tick = (state == ST_RUN) && (div == DIV_LAST);

    // Raster position counters, advanced once per pixel tick. The vertical
    // counter steps only when the horizontal counter wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_tick) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 1'b1;
                end
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

    // Position decode from the current counters; registered on the tick below,
    // which gives the one-clock latency from counter to output pins.
    always_comb begin
        active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
        in_hsync  = (h_cnt >= H_SYNC_BEG) && (h_cnt < H_SYNC_END);
        in_vsync  = (v_cnt >= V_SYNC_BEG) && (v_cnt < V_SYNC_END);
        at_origin = (h_cnt == '0) && (v_cnt == '0);
    end

    // Pop only on an active pixel with data available. Reset masks the strobe
    // so the FIFO never loses a word on a clock whose capture is discarded.
    assign pop        = pix_tick && active && !fifo_empty && !rst;
    assign fifo_rd_en = pop;

    // Registered video outputs. frame_start is a single-clock pulse, so it is
    // cleared on every clock and only re-set on the tick at the origin. An
    // empty FIFO during active video still drives de high with black, which
    // keeps the sink locked; the miss is counted, saturating at all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_r         <= '0;
            vga_g         <= '0;
            vga_b         <= '0;
            de            <= 1'b0;
            hsync         <= ~SYNC_ACTIVE;
            vsync         <= ~SYNC_ACTIVE;
            frame_start   <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            frame_start <= 1'b0;
            if (pix_tick) begin
                de          <= active;
                hsync       <= in_hsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                vsync       <= in_vsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
                frame_start <= at_origin;
                if (pop) begin
                    vga_r <= {8{fifo_data[2]}};
                    vga_g <= {8{fifo_data[1]}};
                    vga_b <= {8{fifo_data[0]}};
                end else begin
                    vga_r <= '0;
                    vga_g <= '0;
                    vga_b <= '0;
                end
                if (active && fifo_empty && underflow_cnt != 16'hFFFF) begin
                    underflow_cnt <= underflow_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dvi_scanout_reader.sv
// ---------------------------------------------------------------------------
// tb_dvi_scanout_reader
//
// Drives dvi_scanout_reader with a shrunken raster so whole frames fit in a
// short run. The bench plays the role of the show-ahead FIFO (a queue of
// random colours, with optional forced starvation) and predicts every output
// from the pixel-tick index: position = tick index mod line/frame length.
// ---------------------------------------------------------------------------
module tb_dvi_scanout_reader;

    localparam int PD = 4;
    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [2:0]  fifo_data;
    logic        fifo_rd_en;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        frame_start;
    logic [15:0] underflow_cnt;

    int checks   = 0;
    int failures = 0;

    logic [2:0] fifo_q[$];

    // Reference model state
    bit          m_run;
    int          m_cyc;
    int          m_p;
    bit          m_de;
    bit          m_hs;
    bit          m_vs;
    bit          m_fs;
    logic [23:0] m_rgb;
    logic [15:0] m_uf;

    always #5 clk = ~clk;

    dvi_scanout_reader #(
        .PIX_DIV(PD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fifo_empty(fifo_empty),
        .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en),
        .vga_r(vga_r),
        .vga_g(vga_g),
        .vga_b(vga_b),
        .hsync(hsync),
        .vsync(vsync),
        .de(de),
        .frame_start(frame_start),
        .underflow_cnt(underflow_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic bit isActive(input int p);
        int h;
        int v;
        h = p % HT;
        v = (p / HT) % VT;
        return (h < HA) && (v < VA);
    endfunction

    task automatic modelReset();
        m_run = 1'b0;
        m_cyc = 0;
        m_p   = 0;
        m_de  = 1'b0;
        m_hs  = 1'b1;
        m_vs  = 1'b1;
        m_fs  = 1'b0;
        m_rgb = '0;
        m_uf  = '0;
    endtask

    // Model of one clock edge: the n-th edge after entering RUN is a pixel
    // tick whenever n is a multiple of PD; tick k shows raster position k.
    task automatic modelEdge(input bit r, input bit e, input logic [2:0] d);
        int  h;
        int  v;
        bit  act;
        bit  tick;
        if (r) begin
            modelReset();
        end else if (!m_run) begin
            if (!e) begin
                m_run = 1'b1;
                m_cyc = 0;
            end
        end else begin
            tick  = ((m_cyc + 1) % PD) == 0;
            m_cyc = m_cyc + 1;
            m_fs  = 1'b0;
            if (tick) begin
                h    = m_p % HT;
                v    = (m_p / HT) % VT;
                act  = (h < HA) && (v < VA);
                m_de = act;
                m_hs = (h >= HA + HF && h < HA + HF + HS) ? 1'b0 : 1'b1;
                m_vs = (v >= VA + VF && v < VA + VF + VS) ? 1'b0 : 1'b1;
                m_fs = (h == 0) && (v == 0);
                m_rgb = (act && !e) ? {{8{d[2]}}, {8{d[1]}}, {8{d[0]}}} : 24'h0;
                if (act && e && m_uf != 16'hFFFF) begin
                    m_uf = m_uf + 1'b1;
                end
                m_p = m_p + 1;
            end
        end
    endtask

    task automatic checkRegistered();
        checkOutput("de", {31'b0, de}, {31'b0, m_de});
        checkOutput("hsync", {31'b0, hsync}, {31'b0, m_hs});
        checkOutput("vsync", {31'b0, vsync}, {31'b0, m_vs});
        checkOutput("frame_start", {31'b0, frame_start}, {31'b0, m_fs});
        checkOutput("rgb", {8'b0, vga_r, vga_g, vga_b}, {8'b0, m_rgb});
        checkOutput("underflow_cnt", {16'b0, underflow_cnt}, {16'b0, m_uf});
    endtask

    // One clock: drive inputs after the falling edge, check everything, then
    // let the rising edge happen and act as the FIFO on the observed strobe.
    task automatic applyStimulus(input bit r, input bit starve);
        bit          exp_rd;
        bit          popped;
        logic [2:0]  d_now;
        while (fifo_q.size() < 4) begin
            fifo_q.push_back(3'($urandom_range(0, 7)));
        end
        rst        = r;
        fifo_empty = starve;
        fifo_data  = fifo_q[0];
        #1;
        checkRegistered();
        exp_rd = !r && m_run && (((m_cyc + 1) % PD) == 0) && isActive(m_p) && !fifo_empty;
        checkOutput("fifo_rd_en", {31'b0, fifo_rd_en}, {31'b0, exp_rd});
        popped = fifo_rd_en;
        d_now  = fifo_data;
        @(posedge clk);
        modelEdge(r, fifo_empty, d_now);
        if (popped) begin
            void'(fifo_q.pop_front());
        end
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b1;
        fifo_empty = 1'b1;
        fifo_data  = 3'b000;
        @(posedge clk);
        @(negedge clk);
        modelReset();

        $display("[TB] reset and idle with empty FIFO");
        repeat (2) applyStimulus(1'b1, 1'b1);
        repeat (30) applyStimulus(1'b0, 1'b1);

        $display("[TB] preload magenta line, then random traffic with starvation");
        fifo_q.delete();
        for (int i = 0; i < HA; i++) begin
            fifo_q.push_back(3'b101);
        end
        repeat (HT * PD + 8) applyStimulus(1'b0, 1'b0);
        repeat (1200) applyStimulus(1'b0, ($urandom_range(0, 7) == 0));

        $display("[TB] mid-frame reset, hold in WAIT, restart");
        repeat (37) applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b1);
        repeat (600) applyStimulus(1'b0, ($urandom_range(0, 5) == 0));

        $display("[TB] reset with FIFO non-empty, immediate restart");
        applyStimulus(1'b1, 1'b0);
        repeat (300) applyStimulus(1'b0, 1'b0);

        #1;
        checkRegistered();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
